qif_neuron_array: RTL and testbench
===================================

Name: qif_neuron_array

Overview:
- Time-multiplexed array of NUM_CH quadratic integrate-and-fire neurons sharing one datapath.
- Generalises the single-neuron QIF block in four ways:
  - parametrised membrane width;
  - per-channel bias current, loaded over a write port;
  - refractory period;
  - spike event stream with a valid/ready handshake.
- Sits between the tile's ui_in/uio pins (bias loading) and the uo_out/uio_out pins (membrane monitor, spike events).

Parameters:
- W, 8, membrane and bias width (unsigned).
- NUM_CH, 4, number of neurons (power of 2, 2..16).
- SQ_SHIFT, 6, right shift applied to V*V.
- LEAK, 0, constant subtracted every update.
- THRESH, 200, spike threshold (V_next >= THRESH fires).
- V_RESET, 0, post-spike and reset membrane value.
- REFRAC, 2, refractory length in visits of that channel (0 disables).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance scan; low freezes all state.
- wr_en  in  1  bias write strobe.
- wr_ch  in  log2(NUM_CH)  bias write channel.
- wr_bias  in  W  bias value.
- mon_ch  in  log2(NUM_CH)  membrane monitor select.
- mon_v  out  W  registered membrane of mon_ch.
- spk_valid  out  1  spike event pending.
- spk_ch  out  log2(NUM_CH)  channel that fired.
- spk_ready  in  1  consumer accepts event.
- spk_vec  out  NUM_CH  sticky per-channel spike flags for the current sweep.
- overflow  out  1  sticky: a spike was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - all V = V_RESET, all bias = 0, all refractory counters = 0, scan pointer = 0;
  - mon_v = V_RESET, spk_valid = 0, spk_ch = 0, spk_vec = 0, overflow = 0.
- Scan:
  - While en=1, one channel c = ptr is updated per cycle; ptr increments modulo NUM_CH.
  - A full sweep takes NUM_CH cycles.
  - en=0 holds ptr, V, counters and the event FIFO state. Handshake pops still proceed while en=0.
- Update of channel c, computed in one cycle and registered at the clock edge:
  - sum = V + ((V*V) >> SQ_SHIFT) + bias[c] - LEAK.
  - V*V is 2W bits wide; sum is evaluated in W+2+W bits.
  - sum is clamped to [0, 2^W-1] to give V_next.
- Refractory: if ref_cnt[c] != 0, then V[c] <= V_RESET and ref_cnt[c] decrements. No integration and no spike occur on that visit.
- Spike: if ref_cnt[c]==0 and V_next >= THRESH, then:
  - V[c] <= V_RESET;
  - ref_cnt[c] <= REFRAC;
  - spk_vec[c] <= 1;
  - an event carrying c is pushed into the event FIFO.
- spk_vec clears to zero at the start of each sweep, i.e. on the cycle ptr wraps to 0. On that wrap cycle, a spike from channel 0 sets bit 0 rather than being cleared.
- Bias write:
  - bias[wr_ch] <= wr_bias on wr_en.
  - If wr_ch equals the channel being updated in the same cycle, the update uses the old bias; the new value applies from the next visit.
- Event FIFO:
  - Depth 4; spk_valid = not empty; spk_ch = head.
  - A pop occurs when spk_valid && spk_ready.
  - A simultaneous push and pop on a full FIFO succeeds.
  - A push to a full FIFO with no pop drops the event and sets overflow, which is sticky until reset.
- Latency: a spike event is visible on spk_valid/spk_ch the cycle after the channel update, when the FIFO was empty.
- mon_v: registered copy of V[mon_ch] as it stood at the previous edge (1-cycle latency).
- Reset mid-sweep aborts the sweep immediately; there is no partial-state retention.

Optional Feature:
- Macro QIF_SPIKE_CNT_EN.
  - Defined: adds per-channel 8-bit saturating spike counters, incremented on every spike (including dropped events). They are readable on the extra output port cnt_out[7:0] selected by mon_ch (registered, 1-cycle latency), and cleared by reset.
  - Undefined: no counters and no cnt_out port; all other behaviour is identical.

Decomposition:
- Package qif_pkg: channel index width function clog2, the saturate-unsigned function, and the FIFO depth constant SPK_FIFO_DEPTH=4.
- Sub-module qif_spike_fifo: parametrised synchronous FIFO holding channel indices, with push/pop/full/empty and a drop flag.
- The QIF datapath stays inline in qif_neuron_array.

Test Plan:
- Reset: rst_n low mid-run -> immediately mon_v=0, spk_valid=0, spk_vec=0, overflow=0.
- Integration, W=8, SQ_SHIFT=6, THRESH=200, LEAK=0:
  - stimulus: bias[0]=10, others 0, spk_ready=1;
  - ch0 V across visits: 10, 21, 37, 68, 150;
  - 6th visit saturates to 255 -> spike: spk_ch=0 for 1 cycle, V[0]=0; other channels stay 0.
- Refractory, REFRAC=2, same stimulus: the two visits after the spike hold V[0]=0. The next visits read 10, 21, ..., and the next spike is on the 6th integrating visit.
- Backpressure: all four channels with bias=255, spk_ready=0:
  - all four spike in sweep 1 and the FIFO fills; spike 5 (sweep 4, after refractory) is dropped -> overflow=1;
  - spk_ready then high -> events drain in order 0, 1, 2, 3.
- Write collision: wr_en with wr_ch=ptr in the update cycle -> that update uses the old bias; the next visit uses the new bias.
- en=0 for 10 cycles mid-sweep -> ptr, V and mon_v unchanged; the queued event still pops with spk_ready=1.

Source files
------------

// File: rtl/qif_pkg.sv
// qif_pkg: shared definitions for the QIF neuron array.
//   clog2          - ceiling log2, used for channel and pointer widths
//   sat_u          - clamp a signed value into the unsigned range [0, 2^w-1]
//   SPK_FIFO_DEPTH - depth of the spike event queue
package qif_pkg;

  localparam int SPK_FIFO_DEPTH = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic longint sat_u(input longint x, input int w);
    longint hi;
    hi = (longint'(1) << w) - 1;
    if (x < 0) return 0;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/qif_spike_fifo.sv
// qif_spike_fifo: small synchronous FIFO of spike channel indices.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, din    - enqueue request and channel index
//   pop          - dequeue request (ignored when empty)
//   dout         - head entry
//   full, empty  - occupancy flags
//   drop         - pulses when a push is refused (full with no pop)
// A push and pop in the same cycle on a full FIFO both succeed.
module qif_spike_fifo import qif_pkg::*; #(
  parameter int DW    = 2,
  parameter int DEPTH = SPK_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        mem[gi] <= '0;
      else if (do_push && (wr_ptr == AW'(gi)))
        mem[gi] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qif_neuron_array.sv
// qif_neuron_array: NUM_CH quadratic integrate-and-fire neurons sharing one
// update datapath; one channel (ptr) is updated per enabled cycle.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   en                 - advance the scan; low freezes neuron and queue state
//   wr_en/wr_ch/wr_bias- per-channel bias write port
//   mon_ch, mon_v      - membrane monitor select and registered membrane value
//   spk_valid/spk_ch/spk_ready - spike event stream (valid/ready)
//   spk_vec            - per-channel spike flags for the current sweep
//   overflow           - sticky, set when a spike event was dropped
//   cnt_out            - (QIF_SPIKE_CNT_EN only) spike count of mon_ch
// Optional feature macro: QIF_SPIKE_CNT_EN adds 8-bit saturating per-channel
// spike counters readable on cnt_out.
module qif_neuron_array import qif_pkg::*; #(
  parameter int W        = 8,
  parameter int NUM_CH   = 4,
  parameter int SQ_SHIFT = 6,
  parameter int LEAK     = 0,
  parameter int THRESH   = 200,
  parameter int V_RESET  = 0,
  parameter int REFRAC   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [clog2(NUM_CH)-1:0] wr_ch,
  input  logic [W-1:0]             wr_bias,
  input  logic [clog2(NUM_CH)-1:0] mon_ch,
  output logic [W-1:0]             mon_v,
  output logic                     spk_valid,
  output logic [clog2(NUM_CH)-1:0] spk_ch,
  input  logic                     spk_ready,
  output logic [NUM_CH-1:0]        spk_vec,
  output logic                     overflow
`ifdef QIF_SPIKE_CNT_EN
  ,
  output logic [7:0]               cnt_out
`endif
);

  localparam int CW = clog2(NUM_CH);
  localparam int SW = 2*W + 2;
  // Wide enough to hold REFRAC, and at least one bit when REFRAC is 0.
  localparam int RW = clog2(REFRAC + 2);
  localparam logic [W-1:0]  V_RST  = W'(V_RESET);
  localparam logic [RW-1:0] REF_LD = RW'(REFRAC);

  logic [CW-1:0] ptr;
  logic [W-1:0]  v_arr    [NUM_CH];
  logic [W-1:0]  bias_arr [NUM_CH];
  logic [RW-1:0] ref_arr  [NUM_CH];

  logic [W-1:0]          v_cur;
  logic [W-1:0]          bias_cur;
  logic [RW-1:0]         ref_cur;
  logic [2*W-1:0]        sq;
  logic [2*W-1:0]        sq_sh;
  logic signed [SW-1:0]  sum;
  longint                sat_l;
  logic [W-1:0]          v_next;
  logic                  refractory;
  logic                  fire;
  logic [NUM_CH-1:0]     hit;

  logic fifo_empty;
  logic fifo_full;
  logic fifo_drop;
  logic fifo_pop;

  // Shared datapath for the channel under the scan pointer.
  assign v_cur      = v_arr[ptr];
  assign bias_cur   = bias_arr[ptr];
  assign ref_cur    = ref_arr[ptr];
  assign sq         = {{W{1'b0}}, v_cur} * {{W{1'b0}}, v_cur};
  assign sq_sh      = sq >> SQ_SHIFT;
  assign sum        = $signed({2'b00, sq_sh})
                    + $signed({{(W+2){1'b0}}, v_cur})
                    + $signed({{(W+2){1'b0}}, bias_cur})
                    - $signed(SW'(LEAK));
  assign sat_l      = sat_u(longint'(sum), W);
  assign v_next     = W'(sat_l);
  assign refractory = (ref_cur != '0);
  assign fire       = !refractory && (sat_l >= longint'(THRESH));
  assign hit        = fire ? (NUM_CH'(1) << ptr) : '0;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic          sel;
    logic [W-1:0]  v_reg;
    logic [W-1:0]  bias_reg;
    logic [RW-1:0] ref_reg;

    assign sel          = en && (ptr == CW'(gi));
    assign v_arr[gi]    = v_reg;
    assign bias_arr[gi] = bias_reg;
    assign ref_arr[gi]  = ref_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg   <= V_RST;
        ref_reg <= '0;
      end else if (sel) begin
        if (refractory) begin
          v_reg   <= V_RST;
          ref_reg <= ref_reg - RW'(1);
        end else if (fire) begin
          v_reg   <= V_RST;
          ref_reg <= REF_LD;
        end else begin
          v_reg   <= v_next;
        end
      end
    end

    // The update reads bias_reg combinationally, so a same-cycle write
    // only takes effect on the next visit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        bias_reg <= '0;
      else if (wr_en && (wr_ch == CW'(gi)))
        bias_reg <= wr_bias;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      spk_vec  <= '0;
      mon_v    <= V_RST;
      overflow <= 1'b0;
    end else begin
      mon_v <= v_arr[mon_ch];
      if (fifo_drop) overflow <= 1'b1;
      if (en) begin
        ptr <= ptr + CW'(1);
        // Channel 0's visit opens a new sweep: clear, but keep its own spike.
        spk_vec <= (ptr == '0) ? hit : (spk_vec | hit);
      end
    end
  end

  assign spk_valid = !fifo_empty;
  assign fifo_pop  = spk_valid && spk_ready;

  qif_spike_fifo #(
    .DW    (CW),
    .DEPTH (SPK_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (en && fire),
    .din   (ptr),
    .pop   (fifo_pop),
    .dout  (spk_ch),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

`ifdef QIF_SPIKE_CNT_EN
  logic [7:0] cnt_arr [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    logic [7:0] cnt_reg;
    assign cnt_arr[gi] = cnt_reg;
    // Counts every spike, including ones whose event was dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_reg <= '0;
      else if (en && (ptr == CW'(gi)) && fire && (cnt_reg != 8'hFF))
        cnt_reg <= cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_out <= '0;
    else        cnt_out <= cnt_arr[mon_ch];
  end
`endif

endmodule

// File: tb/tb_qif_neuron_array.sv
// Self-checking bench for qif_neuron_array: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_qif_neuron_array;

  localparam int W     = 8;
  localparam int N     = 4;
  localparam int SQ    = 6;
  localparam int LK    = 0;
  localparam int TH    = 200;
  localparam int VR    = 0;
  localparam int RF    = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_bias = '0;
  logic [1:0] mon_ch = '0;
  logic [7:0] mon_v;
  logic       spk_valid;
  logic [1:0] spk_ch;
  logic       spk_ready = 1'b0;
  logic [3:0] spk_vec;
  logic       overflow;
`ifdef QIF_SPIKE_CNT_EN
  logic [7:0] cnt_out;
`endif

  qif_neuron_array #(
    .W(W), .NUM_CH(N), .SQ_SHIFT(SQ), .LEAK(LK),
    .THRESH(TH), .V_RESET(VR), .REFRAC(RF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_bias   (wr_bias),
    .mon_ch    (mon_ch),
    .mon_v     (mon_v),
    .spk_valid (spk_valid),
    .spk_ch    (spk_ch),
    .spk_ready (spk_ready),
    .spk_vec   (spk_vec),
    .overflow  (overflow)
`ifdef QIF_SPIKE_CNT_EN
    ,
    .cnt_out   (cnt_out)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_v [N];
  int m_b [N];
  int m_ref [N];
  int m_cnt [N];
  int m_ptr;
  int m_q [$];
  int m_vec;
  int m_ovf;
  int m_mon;
  int m_cnt_out;

  int n_vec = 0;
  int n_err = 0;

  function automatic int qif_step(int v, int b);
    int s;
    s = v + ((v * v) >> SQ) + b - LK;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = VR; m_b[i] = 0; m_ref[i] = 0; m_cnt[i] = 0;
    end
    m_ptr = 0; m_q.delete(); m_vec = 0; m_ovf = 0; m_mon = VR; m_cnt_out = 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void m_step();
    int c;
    int nv;
    bit fire;
    fire = 0;
    c = m_ptr;
    m_mon = m_v[mon_ch];
    m_cnt_out = m_cnt[mon_ch];
    if (en) begin
      if (c == 0) m_vec = 0;
      if (m_ref[c] > 0) begin
        m_v[c] = VR;
        m_ref[c] = m_ref[c] - 1;
      end else begin
        nv = qif_step(m_v[c], m_b[c]);
        if (nv >= TH) begin
          fire = 1;
          m_v[c] = VR;
          m_ref[c] = RF;
          m_vec = m_vec | (1 << c);
          if (m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
        end else begin
          m_v[c] = nv;
        end
      end
      m_ptr = (m_ptr + 1) % N;
    end
    if (m_q.size() > 0 && spk_ready) void'(m_q.pop_front());
    if (fire) begin
      if (m_q.size() < DEPTH) m_q.push_back(c);
      else m_ovf = 1;
    end
    if (wr_en) m_b[wr_ch] = wr_bias;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mon_v"}, 32'(mon_v), 32'(m_mon));
    chk({tag, ".spk_valid"}, 32'(spk_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk({tag, ".spk_ch"}, 32'(spk_ch), 32'(m_q[0]));
    chk({tag, ".spk_vec"}, 32'(spk_vec), 32'(m_vec));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef QIF_SPIKE_CNT_EN
    chk({tag, ".cnt_out"}, 32'(cnt_out), 32'(m_cnt_out));
`endif
  endtask

  task automatic tick(input string tag);
    m_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted away from the edge; outputs must clear at once.
  task automatic do_reset();
    en = 1'b0; wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("rst");
    chk("rst.spk_ch", 32'(spk_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_visit [14] = '{10, 21, 37, 68, 150, 0, 0, 0, 10, 21, 37, 68, 150, 0};

  initial begin
    m_reset();
    #12;
    do_reset();

    // Integration and refractory on channel 0
    wr_en = 1'b1; wr_ch = 2'd0; wr_bias = 8'd10;
    tick("load");
    wr_en = 1'b0; spk_ready = 1'b1; mon_ch = 2'd0; en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick("integ");
      tick("integ");
      chk("visit_v0", 32'(mon_v), 32'(exp_visit[k]));
      tick("integ");
      tick("integ");
    end

    // Mid-run reset
    do_reset();

    // Backpressure: four channels saturating, no consumer
    for (int c = 0; c < N; c++) begin
      wr_en = 1'b1; wr_ch = 2'(c); wr_bias = 8'd255;
      tick("bp_load");
    end
    wr_en = 1'b0; spk_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 4 * N; i++) tick("bp_run");
    chk("bp_overflow", 32'(overflow), 32'd1);
    en = 1'b0; spk_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("bp_order", 32'(spk_ch), 32'(i));
      tick("bp_drain");
    end
    chk("bp_empty", 32'(spk_valid), 32'd0);

    // Bias write colliding with the channel's own update
    do_reset();
    en = 1'b1; mon_ch = 2'd0; spk_ready = 1'b1;
    wr_en = 1'b1; wr_ch = 2'd0; wr_bias = 8'd10;
    tick("coll");
    wr_en = 1'b0;
    tick("coll");
    chk("coll_old_bias", 32'(mon_v), 32'd0);
    tick("coll");
    tick("coll");
    tick("coll");
    tick("coll");
    chk("coll_new_bias", 32'(mon_v), 32'd10);

    // Freeze with an event queued, then pop while frozen
    wr_en = 1'b1; wr_ch = 2'd1; wr_bias = 8'd255;
    tick("hold_load");
    wr_en = 1'b0; spk_ready = 1'b0; mon_ch = 2'd1;
    for (int i = 0; i < 16 && m_q.size() == 0; i++) tick("hold_run");
    chk("hold_queued", 32'(spk_valid), 32'd1);
    tick("hold_run");
    en = 1'b0;
    for (int i = 0; i < 10; i++) tick("hold_frz");
    spk_ready = 1'b1;
    tick("hold_pop");
    chk("hold_popped", 32'(spk_valid), 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      en        = ($urandom_range(0, 3) != 0);
      wr_en     = ($urandom_range(0, 5) == 0);
      wr_ch     = 2'($urandom_range(0, 3));
      wr_bias   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(100, 255))
                                               : 8'($urandom_range(0, 30));
      mon_ch    = 2'($urandom_range(0, 3));
      spk_ready = ($urandom_range(0, 2) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
